// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the register scoreboard.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned SB_CNT_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter: one increment and up to two
// decrements per cycle, applied as a net sum, clamped at zero and at max.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             zero_next
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] net;
    logic             underflow;

    // Net sum of this cycle's events; excess decrements are dropped.
    always_comb begin
        up        = {1'b0, count_q} + SUM_W'(inc);
        net       = up - SUM_W'(dec);
        underflow = 1'b0;
        count_d   = count_q;
        if (up < SUM_W'(dec)) begin
            underflow = 1'b1;
            count_d   = '0;
        end else if (net[CNT_W]) begin
            count_d = '1;
        end else begin
            count_d = net[CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign nonzero   = (count_q != '0);
    assign zero_next = (count_d == '0);

    // A retire or kill for a register with nothing pending is an upstream bug.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !underflow)
        else $error("sb_counter: decrement of empty counter");

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register,
// generates the ID stall and runs an IDLE/DRAIN/DONE quiesce handshake.
// Optional feature macro: SCOREBOARD_STATS_EN adds the StallCnt output.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1Addr_id,
    input  logic [REG_ADDR_W-1:0] rs2Addr_id,
    input  logic                  rs1Used_id,
    input  logic                  rs2Used_id,
    input  logic [REG_ADDR_W-1:0] rdAddr_id,
    input  logic                  RegWrite_id,
    input  logic                  Issue_id,
    input  logic [REG_ADDR_W-1:0] WriteAddr_wb,
    input  logic                  RegWrite_wb,
    input  logic                  Kill_ex,
    input  logic [REG_ADDR_W-1:0] rdAddr_ex,
    input  logic                  RegWrite_ex,
    input  logic                  DrainReq,
    output logic                  Stall_id,
    output logic                  DrainAck,
    output logic [NUM_REGS-1:0]   Busy
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]           StallCnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] zero_nx;
    logic                issue_wr;
    logic                wb_wr;
    logic                kill_wr;
    logic                all_clear;

    sb_state_e state_q, state_d;

    assign issue_wr  = Issue_id && RegWrite_id && !Stall_id && (rdAddr_id != '0);
    assign wb_wr     = RegWrite_wb && (WriteAddr_wb != '0);
    assign kill_wr   = Kill_ex && RegWrite_ex && (rdAddr_ex != '0);

    assign cnt[0]     = '0;
    assign nz[0]      = 1'b0;
    assign zero_nx[0] = 1'b1;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            logic       inc;
            logic [1:0] dec;

            assign inc = issue_wr && (rdAddr_id == REG_ADDR_W'(g));
            assign dec = {1'b0, wb_wr && (WriteAddr_wb == REG_ADDR_W'(g))}
                       + {1'b0, kill_wr && (rdAddr_ex == REG_ADDR_W'(g))};

            sb_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .inc      (inc),
                .dec      (dec),
                .count    (cnt[g]),
                .nonzero  (nz[g]),
                .zero_next(zero_nx[g])
            );
        end
    endgenerate

    assign Busy      = nz;
    assign all_clear = &zero_nx;

    logic             wb_hit1, wb_hit2;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic             raw1, raw2, sat;

    // RAW hazard with WB bypass credit, counter saturation and drain hold.
    always_comb begin
        wb_hit1  = wb_wr && (WriteAddr_wb == rs1Addr_id);
        wb_hit2  = wb_wr && (WriteAddr_wb == rs2Addr_id);
        cnt1     = cnt[rs1Addr_id];
        cnt2     = cnt[rs2Addr_id];
        raw1     = rs1Used_id && (rs1Addr_id != '0) && (cnt1 > CNT_W'(wb_hit1));
        raw2     = rs2Used_id && (rs2Addr_id != '0) && (cnt2 > CNT_W'(wb_hit2));
        sat      = RegWrite_id && (cnt[rdAddr_id] == CNT_MAX);
        Stall_id = raw1 || raw2 || sat || (state_q != ST_IDLE);
    end

    // Drain FSM next-state; the clear test sees this cycle's decrements.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (DrainReq) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!DrainReq)      state_d = ST_IDLE;
                else if (all_clear) state_d = ST_DONE;
            end
            ST_DONE:  if (!DrainReq) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign DrainAck = (state_q == ST_DONE);

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall-cycle count, wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(Stall_id);
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, the width of each per-register in-flight counter (maximum 2^CNT_W-1 pending writes).
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rs1Addr_id  input  5  ID-stage source 1 address.
- rs2Addr_id  input  5  ID-stage source 2 address.
- rs1Used_id  input  1  ID instruction reads rs1.
- rs2Used_id  input  1  ID instruction reads rs2.
- rdAddr_id  input  5  ID-stage destination address.
- RegWrite_id  input  1  ID instruction writes rd.
- Issue_id  input  1  ID instruction advances to EX this cycle.
- WriteAddr_wb  input  5  WB destination address.
- RegWrite_wb  input  1  WB write strobe; retires one pending write.
- Kill_ex  input  1  EX instruction is squashed this cycle.
- rdAddr_ex  input  5  EX destination address.
- RegWrite_ex  input  1  EX instruction writes rd.
- DrainReq  input  1  request to quiesce all pending writes.
- Stall_id  output  1  hold ID; do not issue.
- DrainAck  output  1  pipeline quiescent.
- Busy  output  32  bit i = register i has pending writes; bit 0 always 0.

Function
REQ-003 SHALL keep one CNT_W-bit counter per register 1..31; register 0 is never tracked.
REQ-004 SHALL increment count[rdAddr_id] at the clock edge when Issue_id && RegWrite_id && !Stall_id && rdAddr_id!=0.
REQ-005 SHALL decrement count[WriteAddr_wb] when RegWrite_wb && WriteAddr_wb!=0.
REQ-006 SHALL decrement count[rdAddr_ex] when Kill_ex && RegWrite_ex && rdAddr_ex!=0.
REQ-007 SHALL apply all increments and decrements hitting one register in the same cycle as a net sum (for example +1-1 leaves the count unchanged).
REQ-008 SHALL never underflow a counter: a decrement at 0 is ignored, and the ignored decrement is a verification error.
REQ-009 SHALL drive Stall_id combinationally when rsN is used with rsN!=0 and the effective count of rsN is nonzero; the effective count is count minus 1 if WB retires that register this cycle, because the register file bypasses WB data.
REQ-010 SHALL also assert Stall_id when RegWrite_id && count[rdAddr_id]==2^CNT_W-1, because the counter is saturated.
REQ-011 SHALL also assert Stall_id while the FSM is in DRAIN or DONE.
REQ-012 SHALL drive Busy[i] = (count[i]!=0) from registered state, so it has zero latency after the edge.
REQ-013 SHALL implement the FSM IDLE -> DRAIN -> DONE:
- IDLE -> DRAIN on DrainReq.
- DRAIN -> DONE when all counters are 0, including the decrements of the current cycle.
- DONE -> IDLE when DrainReq deasserts.
- DrainReq dropped while in DRAIN -> IDLE.
REQ-014 SHALL assert DrainAck only in DONE, as a registered output.
REQ-015 SHALL handle DrainReq and a simultaneous all-zero state as IDLE -> DRAIN, then DONE on the next cycle, so DrainAck has a 2-cycle minimum latency.

Reset
REQ-016 SHALL, on rst, clear all counters, return the FSM to IDLE, drive Busy=0, DrainAck=0 and Stall_id=0 (given idle inputs), and clear the statistics counter.
REQ-017 SHALL, when rst asserts mid-drain or with writes pending, discard all state with no completion handshake.

Configuration
REQ-018 SHALL honour macro SCOREBOARD_STATS_EN:
- Defined: adds output StallCnt (32 bits), which increments each cycle Stall_id is 1, wraps from 0xFFFFFFFF to 0, and is cleared by rst.
- Undefined: the port and its logic are absent.

Structure
REQ-019 SHALL take REG_ADDR_W=5, NUM_REGS=32, the default CNT_W and the FSM state encoding (IDLE=0, DRAIN=1, DONE=2) from shared package riscv_pkg.
REQ-020 SHALL instantiate 31 copies of sub-module sb_counter, one per register, each with inc, dec and nonzero outputs and the net-sum and underflow-guard logic.

Verification
REQ-021 SHALL cover these directed scenarios:
- Load-use: issue rd=5, then next ID reads rs1=5 -> Stall_id=1 until the WB retire of x5; Stall_id=0 in the retire cycle due to the bypass.
- Same-cycle inc/dec: issue rd=7 while WB retires x7 with count=1 -> count stays 1, Busy[7]=1.
- x0: issue rd=0, then read rs1=0 -> Busy=0, Stall_id=0.
- Saturation (CNT_W=2): three issues to rd=3 -> count=3; a fourth writing x3 -> Stall_id=1 and count stays 3.
- Kill: issue rd=9, then Kill_ex with rdAddr_ex=9 -> Busy[9]=0 next cycle, and a reader of x9 does not stall.
- Drain: two writes pending and DrainReq=1 -> Stall_id=1; DrainAck=1 the cycle after the last retire; DrainReq=0 -> IDLE; rst mid-drain -> DrainAck=0 and Busy=0.
